// File: rtl/bcd_segment_scanner.sv
// bcd_segment_scanner: captures a binary value, converts it to BCD with a
// one-shift-per-clock double-dabble engine, then time-multiplexes DIGITS
// common-anode seven-segment digits with leading-zero blanking, per-digit
// decimal points and an overflow (all-dash) indication.
module bcd_segment_scanner #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 200000
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic [BIN_W-1:0]  number,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic              dp_out,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] acc;
    acc = 64'd1;
    for (int k = 0; k < n; k++) acc = acc * 64'd10;
    return acc;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} stateType;

  stateType          state, stateNext;
  logic [BIN_W-1:0]  binReg;
  logic [BCD_W-1:0]  bcdReg, bcdAdj, dispReg;
  logic [CNT_W-1:0]  bitCnt;
  logic              ovfNext;
  logic [PRE_W-1:0]  prescaler;
  logic [IDX_W-1:0]  index, nextIndex;
  logic              terminal;
  logic [3:0]        nibble;
  logic              dpBit, lzBlank;
  logic [6:0]        decoded, segNext;
  logic              dpNext;
  logic [DIGITS-1:0] anNext;

  assign busy = (state != IDLE);

  // Conversion FSM state register; reset aborts any conversion in flight.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic: load starts a conversion, the last shift leads to commit.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (load) stateNext = SHIFT;
      SHIFT:   if (bitCnt == CNT_W'(1)) stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more before shifting.
  always_comb begin
    bcdAdj = bcdReg;
    for (int j = 0; j < DIGITS; j++) begin
      if (bcdReg[4*j +: 4] >= 4'd5) bcdAdj[4*j +: 4] = bcdReg[4*j +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture on load, shift while converting, publish on commit.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      binReg   <= '0;
      bcdReg   <= '0;
      bitCnt   <= '0;
      ovfNext  <= 1'b0;
      dispReg  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            binReg  <= number;
            bcdReg  <= '0;
            bitCnt  <= CNT_W'(BIN_W);
            ovfNext <= (64'(number) >= LIMIT);
          end
        end
        SHIFT: begin
          {bcdReg, binReg} <= {bcdAdj, binReg} << 1;
          bitCnt           <= bitCnt - 1'b1;
        end
        COMMIT: begin
          dispReg  <= bcdReg;
          overflow <= ovfNext;
        end
        default: ;
      endcase
    end
  end

  assign terminal  = (prescaler == PRE_W'(SCAN_DIV - 1));
  assign nextIndex = (index == IDX_W'(DIGITS - 1)) ? '0 : index + 1'b1;

  // Pin values for the digit about to be scanned, including zero blanking and overflow dashes.
  always_comb begin
    nibble  = 4'd0;
    dpBit   = 1'b0;
    anNext  = '1;
    lzBlank = blank_lz && (nextIndex != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) == nextIndex) begin
        nibble    = dispReg[4*j +: 4];
        dpBit     = dp[j];
        anNext[j] = 1'b0;
      end
      if ((IDX_W'(j) >= nextIndex) && (dispReg[4*j +: 4] != 4'd0)) lzBlank = 1'b0;
    end
    case (nibble)
      4'd0:    decoded = 7'b1000000;
      4'd1:    decoded = 7'b1111001;
      4'd2:    decoded = 7'b0100100;
      4'd3:    decoded = 7'b0110000;
      4'd4:    decoded = 7'b0011001;
      4'd5:    decoded = 7'b0010010;
      4'd6:    decoded = 7'b0000010;
      4'd7:    decoded = 7'b1111000;
      4'd8:    decoded = 7'b0000000;
      4'd9:    decoded = 7'b0010000;
      default: decoded = SEG_BLANK;
    endcase
    if (overflow)     segNext = SEG_DASH;
    else if (lzBlank) segNext = SEG_BLANK;
    else              segNext = decoded;
    dpNext = overflow ? 1'b1 : ~dpBit;
  end

  // Scan prescaler and digit index; the pins only change at a slot boundary.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      prescaler <= '0;
      index     <= IDX_W'(DIGITS - 1);
      seg       <= SEG_BLANK;
      dp_out    <= 1'b1;
      an        <= '1;
    end else if (terminal) begin
      prescaler <= '0;
      index     <= nextIndex;
      seg       <= segNext;
      dp_out    <= dpNext;
      an        <= anNext;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_segment_scanner.sv
// tb_bcd_segment_scanner: directed stimulus against bcd_segment_scanner with a
// decimal-arithmetic reference model compared on every cycle, plus literal
// expectations for the key display patterns.
module tb_bcd_segment_scanner;

  localparam int DIGITS   = 4;
  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic              CLOCK = 1'b0;
  logic              RESETN = 1'b1;
  logic [BIN_W-1:0]  number = '0;
  logic              load = 1'b0;
  logic              blank_lz = 1'b0;
  logic [DIGITS-1:0] dp = '0;
  logic              busy, overflow, dp_out;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  logic [6:0] segTable [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pw [0:DIGITS] = '{1, 10, 100, 1000, 10000};

  bcd_segment_scanner #(.DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .number(number), .load(load), .blank_lz(blank_lz),
    .dp(dp), .busy(busy), .overflow(overflow), .seg(seg), .dp_out(dp_out), .an(an)
  );

  // 100 MHz style clock
  always #5 CLOCK = ~CLOCK;

  // Reference model state: displayed decimal value and what the pins must show
  int         mVal = 0;
  int         mPend = 0;
  bit         mOvf = 1'b0;
  int         mBusyCnt = 0;
  int         mTick = 0;
  int         mIdx = DIGITS - 1;
  logic [3:0] mAn = 4'hF;
  logic [6:0] mSeg = 7'h7F;
  logic       mDp = 1'b1;

  function automatic logic [6:0] expSeg(input int v, input bit ovf, input int i, input bit blz);
    if (ovf) return 7'b0111111;
    if (blz && i > 0 && v < pw[i]) return 7'b1111111;
    return segTable[(v / pw[i]) % 10];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decimal digit extraction on slot boundaries, a busy countdown per accepted load
  always @(posedge CLOCK or negedge RESETN) begin : model
    int ni;
    if (!RESETN) begin
      mVal <= 0; mPend <= 0; mOvf <= 1'b0; mBusyCnt <= 0; mTick <= 0;
      mIdx <= DIGITS - 1; mAn <= 4'hF; mSeg <= 7'h7F; mDp <= 1'b1;
    end else begin
      if (mTick == SCAN_DIV - 1) begin
        ni = (mIdx + 1) % DIGITS;
        mTick <= 0;
        mIdx  <= ni;
        mAn   <= ~(4'b0001 << ni);
        mSeg  <= expSeg(mVal, mOvf, ni, blank_lz);
        mDp   <= mOvf ? 1'b1 : ~dp[ni];
      end else begin
        mTick <= mTick + 1;
      end
      if (mBusyCnt == 0) begin
        if (load) begin
          mPend    <= int'(number);
          mBusyCnt <= BIN_W + 1;
        end
      end else begin
        mBusyCnt <= mBusyCnt - 1;
        if (mBusyCnt == 1) begin
          mVal <= mPend;
          mOvf <= (mPend >= pw[DIGITS]);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLOCK) begin
    if (checkEn) begin
      checkOutput("model an", an, mAn);
      checkOutput("model seg", seg, mSeg);
      checkOutput("model dp_out", dp_out, mDp);
      checkOutput("model busy", busy, (mBusyCnt > 0));
      checkOutput("model overflow", overflow, mOvf);
    end
  end

  task automatic applyStimulus(input int value);
    @(negedge CLOCK);
    number = BIN_W'(value);
    load   = 1'b1;
    @(negedge CLOCK);
    load   = 1'b0;
  endtask

  task automatic waitBusyDone(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge CLOCK);
    end
    if (busy) checkOutput("busy timeout", busy, 1'b0);
  endtask

  task automatic waitDigit(input logic [3:0] anWant, input logic [6:0] segWant,
                           input logic dpWant, input string name);
    for (int k = 0; k < 4 * SCAN_DIV + 2 && an !== anWant; k++) @(negedge CLOCK);
    checkOutput({name, " an"}, an, anWant);
    checkOutput({name, " seg"}, seg, segWant);
    checkOutput({name, " dp_out"}, dp_out, dpWant);
  endtask

  int vals [5] = '{0, 10, 305, 9000, 16383};
  bit blzs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int n;
    #1 RESETN = 1'b0;
    repeat (3) @(negedge CLOCK);
    checkEn = 1'b1;
    @(negedge CLOCK);
    RESETN = 1'b1;
    repeat (3) begin
      @(posedge CLOCK); #1;
      checkOutput("pre-scan an", an, 4'hF);
      checkOutput("pre-scan seg", seg, 7'h7F);
      checkOutput("pre-scan busy", busy, 1'b0);
    end
    @(posedge CLOCK); #1;
    checkOutput("first slot an", an, 4'b1110);
    checkOutput("first slot seg", seg, 7'b1000000);

    applyStimulus(1234);
    waitBusyDone(n);
    checkOutput("busy length 1234", n, 15);
    repeat (SCAN_DIV + 1) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b0011001, 1'b1, "1234 d0");
    waitDigit(4'b1101, 7'b0110000, 1'b1, "1234 d1");
    waitDigit(4'b1011, 7'b0100100, 1'b1, "1234 d2");
    waitDigit(4'b0111, 7'b1111001, 1'b1, "1234 d3");

    blank_lz = 1'b1;
    dp = 4'b0100;
    applyStimulus(7);
    waitBusyDone(n);
    repeat (SCAN_DIV + 1) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b1111000, 1'b1, "7 d0");
    waitDigit(4'b1101, 7'b1111111, 1'b1, "7 d1");
    waitDigit(4'b1011, 7'b1111111, 1'b0, "7 d2");
    waitDigit(4'b0111, 7'b1111111, 1'b1, "7 d3");

    applyStimulus(10000);
    waitBusyDone(n);
    checkOutput("overflow 10000", overflow, 1'b1);
    repeat (SCAN_DIV + 1) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b0111111, 1'b1, "10000 d0");
    waitDigit(4'b1011, 7'b0111111, 1'b1, "10000 d2");

    applyStimulus(9999);
    waitBusyDone(n);
    checkOutput("overflow 9999", overflow, 1'b0);
    repeat (SCAN_DIV + 1) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b0010000, 1'b1, "9999 d0");
    waitDigit(4'b1011, 7'b0010000, 1'b0, "9999 d2");

    @(negedge CLOCK);
    number = BIN_W'(5);
    load   = 1'b1;
    @(negedge CLOCK);
    number = BIN_W'(42);
    @(negedge CLOCK);
    load   = 1'b0;
    waitBusyDone(n);
    checkOutput("busy length ignored load", n, 14);
    repeat (SCAN_DIV + 1) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b0010010, 1'b1, "5 d0");
    waitDigit(4'b1101, 7'b1111111, 1'b1, "5 d1");

    dp = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      blank_lz = blzs[i];
      applyStimulus(vals[i]);
      waitBusyDone(n);
      repeat (4 * SCAN_DIV + 2) @(negedge CLOCK);
    end
    waitDigit(4'b0111, 7'b0111111, 1'b1, "16383 d3");

    blank_lz = 1'b1;
    dp = 4'b0000;
    applyStimulus(1234);
    repeat (6) @(posedge CLOCK);
    #2 RESETN = 1'b0;
    #1;
    checkOutput("abort an", an, 4'hF);
    checkOutput("abort seg", seg, 7'h7F);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort dp_out", dp_out, 1'b1);
    checkOutput("abort overflow", overflow, 1'b0);
    repeat (2) @(negedge CLOCK);
    RESETN = 1'b1;
    repeat (20) @(negedge CLOCK);
    waitDigit(4'b1110, 7'b1000000, 1'b1, "after abort d0");
    waitDigit(4'b1101, 7'b1111111, 1'b1, "after abort d1");

    repeat (2) @(negedge CLOCK);
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
